seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 191 +++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with double-buffered digits.
// Latency: outputs are registered and follow the scan FSM with no extra cycle;
//    a load shows up at the first frame start after the frame in which it is accepted.
// Backpressure: ready drops while a pending frame waits; load with ready low is dropped.
//
// Ports:
//    clk, reset      - single clock, asynchronous active-high reset
//    load            - request to capture digits_in/dp_in (accepted when ready)
//    digits_in[15:0] - four hex codes, [3:0] = digit 0 (rightmost)
//    dp_in[3:0]      - decimal point enable per digit
//    blank_lz        - leading-zero blanking enable, sampled every cycle
//    ready           - pending buffer empty, a load will be accepted
//    segments[6:0]   - active-high segments, bit order gfedcba
//    dp              - active-high decimal point
//    digit_en[3:0]   - active-high digit select, one-hot or zero
//    frame_done      - one-cycle pulse on the last drive cycle of digit 3

module seg_scan_driver #(
   parameter int SCAN_DIV     = 4,
   parameter int BLANK_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic        blank_lz,
   output logic        ready,
   output logic [6:0]  segments,
   output logic        dp,
   output logic [3:0]  digit_en,
   output logic        frame_done
);

   typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

   localparam logic [9:0] LP_DRV_LAST = 10'(SCAN_DIV - 1);
   // Only meaningful when BLANK_CYCLES > 0; the zero case is handled by LP_NO_BLANK.
   localparam logic [9:0] LP_BLK_LAST = 10'(BLANK_CYCLES - 1);
   localparam logic       LP_NO_BLANK = (BLANK_CYCLES == 0);

   // Scan state
   state_t      r_state;
   logic [1:0]  r_digit;
   logic [9:0]  r_cnt;

   // Display buffers
   logic [15:0] r_active;
   logic [3:0]  r_active_dp;
   logic [15:0] r_pend;
   logic [3:0]  r_pend_dp;
   logic        r_pend_vld;

   // Registered outputs
   logic [6:0]  r_segments;
   logic        r_dp;
   logic [3:0]  r_digit_en;
   logic        r_frame_done;

   // Next-state values
   state_t      w_state_nxt;
   logic [1:0]  w_digit_nxt;
   logic [9:0]  w_cnt_nxt;
   logic        w_xfer;
   logic [15:0] w_active_nxt;
   logic [3:0]  w_active_dp_nxt;
   logic [3:0]  w_nib;
   logic        w_lz;
   logic        w_drive;
   logic [6:0]  w_seg_nxt;
   logic        w_dp_nxt;
   logic [3:0]  w_en_nxt;
   logic        w_fd_nxt;
   logic        w_accept;

   function automatic logic [6:0] f_decode(input logic [3:0] code);
      logic [6:0] seg;
      case (code)
         4'h0:    seg = 7'b0111111;
         4'h1:    seg = 7'b0000110;
         4'h2:    seg = 7'b1011011;
         4'h3:    seg = 7'b1001111;
         4'h4:    seg = 7'b1100110;
         4'h5:    seg = 7'b1101101;
         4'h6:    seg = 7'b1111101;
         4'h7:    seg = 7'b0000111;
         4'h8:    seg = 7'b1111111;
         4'h9:    seg = 7'b1101111;
         4'hA:    seg = 7'b1110111;
         4'hB:    seg = 7'b1111100;
         4'hC:    seg = 7'b0111001;
         4'hD:    seg = 7'b1011110;
         4'hE:    seg = 7'b1111001;
         default: seg = 7'b0000000;
      endcase
      return seg;
   endfunction

   assign ready    = !r_pend_vld;
   assign w_accept = load && !r_pend_vld;

   // Scan sequencing: BLANK (skipped when BLANK_CYCLES = 0) then DRIVE per digit.
   always_comb begin
      w_state_nxt = r_state;
      w_digit_nxt = r_digit;
      w_cnt_nxt   = r_cnt + 10'd1;
      case (r_state)
         ST_BLANK: begin
            if (LP_NO_BLANK || (r_cnt == LP_BLK_LAST)) begin
               w_state_nxt = ST_DRIVE;
               w_cnt_nxt   = 10'd0;
            end
         end
         default: begin
            if (r_cnt == LP_DRV_LAST) begin
               w_digit_nxt = r_digit + 2'd1;
               w_cnt_nxt   = 10'd0;
               w_state_nxt = LP_NO_BLANK ? ST_DRIVE : ST_BLANK;
            end
         end
      endcase
   end

   // The frame_done cycle is the last cycle of a frame, so the swap lands on the
   // same edge that starts digit 0 of the next frame. Output decode looks at the
   // post-swap value so a zero-blank configuration never shows a stale digit.
   assign w_xfer          = r_frame_done && r_pend_vld;
   assign w_active_nxt    = w_xfer ? r_pend    : r_active;
   assign w_active_dp_nxt = w_xfer ? r_pend_dp : r_active_dp;

   assign w_nib   = w_active_nxt[{w_digit_nxt, 2'b00} +: 4];
   assign w_drive = (w_state_nxt == ST_DRIVE);

   // Digit i is a leading zero when it and every digit to its left are zero.
   always_comb begin
      w_lz = 1'b0;
      case (w_digit_nxt)
         2'd1:    w_lz = (w_active_nxt[15:4]  == 12'd0);
         2'd2:    w_lz = (w_active_nxt[15:8]  == 8'd0);
         2'd3:    w_lz = (w_active_nxt[15:12] == 4'd0);
         default: w_lz = 1'b0;
      endcase
      w_lz = w_lz && blank_lz;
   end

   assign w_seg_nxt = (w_drive && !w_lz) ? f_decode(w_nib) : 7'd0;
   assign w_dp_nxt  = w_drive && w_active_dp_nxt[w_digit_nxt];
   assign w_en_nxt  = w_drive ? (4'b0001 << w_digit_nxt) : 4'b0000;
   assign w_fd_nxt  = w_drive && (w_digit_nxt == 2'd3) && (w_cnt_nxt == LP_DRV_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_BLANK;
         r_digit      <= 2'd0;
         r_cnt        <= 10'd0;
         r_active     <= 16'd0;
         r_active_dp  <= 4'd0;
         r_pend       <= 16'd0;
         r_pend_dp    <= 4'd0;
         r_pend_vld   <= 1'b0;
         r_segments   <= 7'd0;
         r_dp         <= 1'b0;
         r_digit_en   <= 4'd0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_digit      <= w_digit_nxt;
         r_cnt        <= w_cnt_nxt;
         r_active     <= w_active_nxt;
         r_active_dp  <= w_active_dp_nxt;
         r_segments   <= w_seg_nxt;
         r_dp         <= w_dp_nxt;
         r_digit_en   <= w_en_nxt;
         r_frame_done <= w_fd_nxt;
         // Accept and swap are exclusive: accept needs the flag clear, swap needs it set.
         if (w_accept) begin
            r_pend     <= digits_in;
            r_pend_dp  <= dp_in;
            r_pend_vld <= 1'b1;
         end else if (w_xfer) begin
            r_pend_vld <= 1'b0;
         end
      end
   end

   assign segments   = r_segments;
   assign dp         = r_dp;
   assign digit_en   = r_digit_en;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with default parameters (SCAN_DIV=4, BLANK_CYCLES=1).
// Reference model: frame position = cycle mod 20, digit = pos/5, driven when pos%5 != 0.
// Buffers modelled as plain variables updated at frame ends.

module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic        ready;
   logic [6:0]  segments;
   logic        dp;
   logic [3:0]  digit_en;
   logic        frame_done;

   seg_scan_driver dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .ready      (ready),
      .segments   (segments),
      .dp         (dp),
      .digit_en   (digit_en),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state
   int          t;
   logic [15:0] m_act, m_pend;
   logic [3:0]  m_act_dp, m_pend_dp;
   bit          m_pv;
   bit          m_lz_prev;

   logic [6:0] dec_tbl [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                                7'b0111001, 7'b1011110, 7'b1111001, 7'b0000000};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, t);
      end
   endtask

   task automatic check_outputs();
      int p, d;
      bit drv, lz;
      logic [6:0] e_seg;
      logic [3:0] e_en;
      logic       e_dp;
      p   = t % 20;
      d   = p / 5;
      drv = (p % 5) != 0;
      lz  = m_lz_prev && (d > 0) && ((m_act >> (4 * d)) == 16'd0);
      e_seg = (drv && !lz) ? dec_tbl[(m_act >> (4 * d)) & 16'hF] : 7'd0;
      e_en  = drv ? 4'(1 << d) : 4'd0;
      e_dp  = drv ? m_act_dp[d] : 1'b0;
      check("segments", {25'd0, segments}, {25'd0, e_seg});
      check("digit_en", {28'd0, digit_en}, {28'd0, e_en});
      check("dp", {31'd0, dp}, {31'd0, e_dp});
      check("frame_done", {31'd0, frame_done}, {31'd0, (p == 19)});
      check("ready", {31'd0, ready}, {31'd0, !m_pv});
   endtask

   // One clock cycle: called at a negedge with inputs already set.
   task automatic step();
      check_outputs();
      @(posedge clk);
      if (load && !m_pv) begin
         m_pend    = digits_in;
         m_pend_dp = dp_in;
         m_pv      = 1'b1;
      end else if ((t % 20) == 19 && m_pv) begin
         m_act    = m_pend;
         m_act_dp = m_pend_dp;
         m_pv     = 1'b0;
      end
      m_lz_prev = blank_lz;
      t++;
      @(negedge clk);
   endtask

   task automatic cyc(input bit ld, input logic [15:0] dg, input logic [3:0] dpv);
      load      = ld;
      digits_in = dg;
      dp_in     = dpv;
      step();
      load = 1'b0;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 16'h0, 4'h0);
   endtask

   // Asserted at a negedge so the asynchronous clear is observed mid-cycle.
   task automatic do_reset();
      load  = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_segments", {25'd0, segments}, 32'd0);
      check("rst_digit_en", {28'd0, digit_en}, 32'd0);
      check("rst_dp", {31'd0, dp}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      reset     = 1'b0;
      t         = 0;
      m_act     = 16'd0;
      m_pend    = 16'd0;
      m_act_dp  = 4'd0;
      m_pend_dp = 4'd0;
      m_pv      = 1'b0;
      m_lz_prev = blank_lz;
   endtask

   task automatic wait_slot(input int pos, input bit need_empty);
      int k;
      k = 0;
      while (k < 200 && !((t % 20) == pos && (!need_empty || !m_pv))) begin
         cyc(1'b0, 16'h0, 4'h0);
         k++;
      end
      check("wait_slot_timeout", {31'd0, (k < 200)}, 32'd1);
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] v;
      for (int i = 0; i < 4; i++)
         v[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      return v;
   endfunction

   initial begin
      reset     = 1'b1;
      load      = 1'b0;
      digits_in = 16'h0;
      dp_in     = 4'h0;
      blank_lz  = 1'b0;
      t         = 0;
      @(negedge clk);
      do_reset();

      // Defaults after reset, load at cycle 3, ignored load while busy.
      for (int k = 0; k < 62; k++) begin
         if (t == 3)      cyc(1'b1, 16'h1234, 4'b0100);
         else if (t == 8) cyc(1'b1, 16'h9999, 4'b1111);
         else             cyc(1'b0, 16'h0, 4'h0);
      end

      // Leading-zero blanking.
      blank_lz = 1'b1;
      wait_slot(0, 1'b1);
      cyc(1'b1, 16'h0040, 4'b0000);
      run(45);
      wait_slot(0, 1'b1);
      cyc(1'b1, 16'h0000, 4'b0001);
      run(45);
      blank_lz = 1'b0;

      // Hex letters and the 0xF blank code.
      wait_slot(2, 1'b1);
      cyc(1'b1, 16'hABCD, 4'b1010);
      run(40);
      wait_slot(7, 1'b1);
      cyc(1'b1, 16'hEF0F, 4'b0101);
      run(40);

      // Reset during digit 2 drive with a pending frame waiting.
      wait_slot(5, 1'b1);
      cyc(1'b1, 16'h5678, 4'b1111);
      wait_slot(12, 1'b0);
      check("pending_before_reset", {31'd0, m_pv}, 32'd1);
      do_reset();
      run(25);

      // Randomized traffic.
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 5) == 0) cyc(1'b1, rand_digits(), 4'($urandom_range(0, 15)));
         else                          cyc(1'b0, 16'($urandom), 4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
